// File: rtl/bitwise_pkg.sv
// bitwise_pkg: shared types and the bitwise op helper for the operand loader
// and the downstream OR/AND output stage.
//   op_e            - operation select carried with the A beat
//   loader_state_e  - pairing FSM states
//   apply_op()      - bitwise op over OP_MAX_W bits; callers cast in and out
package bitwise_pkg;

    // Widest operand apply_op() handles. Bitwise ops are width-independent,
    // so narrower callers zero-extend and truncate back without loss.
    localparam int unsigned OP_MAX_W = 64;

    typedef enum logic [1:0] {
        OP_OR   = 2'b00,
        OP_AND  = 2'b01,
        OP_XOR  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HAVE_A = 2'b01,
        EMIT   = 2'b10
    } loader_state_e;

    function automatic logic [OP_MAX_W-1:0] apply_op(
        input op_e                 op,
        input logic [OP_MAX_W-1:0] a,
        input logic [OP_MAX_W-1:0] b
    );
        logic [OP_MAX_W-1:0] r;
        case (op)
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/operand_pair_loader_if.sv
// operand_pair_loader_if: operand input bus plus result output bus.
//   in_valid/in_ready/in_data/in_op : operand beats into the loader
//   out_valid/out_ready/out_data    : FIFO head towards the output stage
//   level                           : FIFO occupancy
// master = traffic source / result consumer, slave = the loader.
interface operand_pair_loader_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [LVL_W-1:0] level;

    modport master (
        output in_valid, in_data, in_op, out_ready,
        input  in_ready, out_valid, out_data, level
    );

    modport slave (
        input  in_valid, in_data, in_op, out_ready,
        output in_ready, out_valid, out_data, level
    );
endinterface

// File: rtl/operand_pair_loader_result_fifo.sv
// result_fifo: synchronous single-clock FIFO for paired results.
//   clk, rst      : clock, async active-high reset
//   push_i/data_i : write request (refused while full)
//   pop_i         : read request (ignored while empty)
//   data_o        : head entry, 0 when empty
//   valid_o       : non-empty
//   full_o        : level == DEPTH
//   level_o       : occupancy
// All outputs are registered; full/empty come from the level counter.
module result_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       valid_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             push_ok;
    logic             pop_ok;

    // Next pointers/level, and next head value so data_o can be registered.
    always_comb begin
        push_ok  = push_i && !full_q;
        pop_ok   = pop_i && valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        data_d   = '0;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        // The new head may be the entry being written this very cycle.
        if (level_d != '0) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) data_d = data_i;
            else                                   data_d = mem_q[rd_ptr_d];
        end
        valid_d = (level_d != '0);
        full_d  = (level_d == LVL_W'(DEPTH));
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    // Storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign full_o  = full_q;
    assign level_o = level_q;

endmodule

// File: rtl/operand_pair_loader.sv
// operand_pair_loader: pairs operand beats (A then B), applies the op chosen
// on the A beat and queues the results in result_fifo.
//   clk  : clock, rising edge
//   rst  : async active-high reset
//   bus  : operand_pair_loader_if.slave
//          in_valid/in_ready/in_data/in_op  - operand beats
//          out_valid/out_ready/out_data     - FIFO head
//          level                            - FIFO occupancy
module operand_pair_loader
    import bitwise_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    operand_pair_loader_if.slave  bus
);
    loader_state_e    state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             in_ready_q, in_ready_d;
    logic             in_fire;
    logic             push;
    logic             fifo_full;

    assign in_fire = bus.in_valid && in_ready_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            op_q       <= OP_OR;
            res_q      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            op_q       <= op_d;
            res_q      <= res_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_fire) state_d = HAVE_A;
            HAVE_A:  if (in_fire) state_d = EMIT;
            EMIT:    if (!fifo_full) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic; a full FIFO holds res_q in EMIT and retries.
    always_comb begin
        a_d        = a_q;
        op_d       = op_q;
        res_d      = res_q;
        push       = 1'b0;
        in_ready_d = (state_d != EMIT);
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    a_d  = bus.in_data;
                    op_d = op_e'(bus.in_op);
                end
            end
            HAVE_A: begin
                if (in_fire) begin
                    res_d = WIDTH'(apply_op(op_q, OP_MAX_W'(a_q), OP_MAX_W'(bus.in_data)));
                end
            end
            EMIT:    push = !fifo_full;
            default: ;
        endcase
    end

    assign bus.in_ready = in_ready_q;

    result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (res_q),
        .pop_i   (bus.out_ready),
        .data_o  (bus.out_data),
        .valid_o (bus.out_valid),
        .full_o  (fifo_full),
        .level_o (bus.level)
    );

endmodule
